// File: rtl/tmr_scrub_pkg.sv
// tmr_scrub_pkg: shared FSM state type, default sizing and per-bit TMR vote helpers
package tmr_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VOTE = 2'd1,
        FIX  = 2'd2
    } scrubState_t;

    localparam int DEF_N_REGS       = 8;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_SCRUB_PERIOD = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Which of the three copies disagree with the majority on this bit, as {C,B,A}
    function automatic logic [2:0] bitMismatch(input logic a, input logic b, input logic c);
        logic m;
        m = maj3(a, b, c);
        return {c ^ m, b ^ m, a ^ m};
    endfunction

endpackage

// File: rtl/tmr_vote3.sv
// tmr_vote3: bitwise majority of three words plus {C,B,A} mask of copies that differ from it
module tmr_vote3
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic [2:0]       mismatch
);

    // A copy mismatches when any one of its bits loses the vote
    always_comb begin
        voted    = '0;
        mismatch = '0;
        for (int i = 0; i < WIDTH; i++) begin
            voted[i] = maj3(a[i], b[i], c[i]);
            mismatch = mismatch | bitMismatch(a[i], b[i], c[i]);
        end
    end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: triplicated register file with voted reads, fault injection and periodic scrubbing
module tmr_scrub_ctrl
    import tmr_scrub_pkg::*;
#(
    parameter int N_REGS       = DEF_N_REGS,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int SCRUB_PERIOD = DEF_SCRUB_PERIOD,
    localparam int AW          = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             scrub_en,
    input  logic             inj_en,
    input  logic [AW-1:0]    inj_addr,
    input  logic [1:0]       inj_copy,
    input  logic [WIDTH-1:0] inj_mask,
    output logic             err_pulse,
    output logic [AW-1:0]    err_addr,
    output logic [2:0]       err_copy,
    output logic [15:0]      err_cnt,
    input  logic             err_cnt_clr,
    output logic             busy
);

    localparam int TW = $clog2(SCRUB_PERIOD + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCRUB_PERIOD - 1);

    logic [WIDTH-1:0] copyA [N_REGS];
    logic [WIDTH-1:0] copyB [N_REGS];
    logic [WIDTH-1:0] copyC [N_REGS];

    scrubState_t      state, stateNext;
    logic [TW-1:0]    timer;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] rdVoted, scrubVoted, votedReg;
    logic [2:0]       scrubMask, maskReg, unusedRdMask;
    logic [15:0]      errCnt;
    logic             wrHitsPtr, ptrInc, fixWrite;

    tmr_vote3 #(.WIDTH(WIDTH)) uRdVote (
        .a        (copyA[rd_addr]),
        .b        (copyB[rd_addr]),
        .c        (copyC[rd_addr]),
        .voted    (rdVoted),
        .mismatch (unusedRdMask)
    );

    tmr_vote3 #(.WIDTH(WIDTH)) uScrubVote (
        .a        (copyA[ptr]),
        .b        (copyB[ptr]),
        .c        (copyC[ptr]),
        .voted    (scrubVoted),
        .mismatch (scrubMask)
    );

    assign wrHitsPtr = wr_en && (wr_addr == ptr);
    assign busy      = (state != IDLE);
    assign err_cnt   = errCnt;

    // Scrub state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= stateNext;
    end

    // Next state; a user write to the scrubbed address cancels the pass but still advances ptr
    always_comb begin
        stateNext = state;
        ptrInc    = 1'b0;
        fixWrite  = 1'b0;
        case (state)
            IDLE: stateNext = (scrub_en && timer == TIMER_LAST) ? VOTE : IDLE;
            VOTE: begin
                stateNext = (wrHitsPtr || ~|scrubMask) ? IDLE : FIX;
                ptrInc    = wrHitsPtr || ~|scrubMask;
            end
            FIX: begin
                stateNext = IDLE;
                ptrInc    = 1'b1;
                fixWrite  = !wrHitsPtr;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Idle interval timer; only counts while idle with scrubbing enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                                  timer <= '0;
        else if (state != IDLE || !scrub_en || timer == TIMER_LAST) timer <= '0;
        else                                                        timer <= timer + 1'b1;
    end

    // Scrub pointer and the vote snapshot taken in VOTE for use in FIX
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr      <= '0;
            votedReg <= '0;
            maskReg  <= '0;
        end else begin
            if (ptrInc)        ptr <= ptr + 1'b1;
            if (state == VOTE) begin
                votedReg <= scrubVoted;
                maskReg  <= scrubMask;
            end
        end
    end

    // Storage: user write beats fix write-back, which beats fault injection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REGS; i++) begin
                copyA[i] <= '0;
                copyB[i] <= '0;
                copyC[i] <= '0;
            end
        end else begin
            if (inj_en) begin
                case (inj_copy)
                    2'd0:    copyA[inj_addr] <= copyA[inj_addr] ^ inj_mask;
                    2'd1:    copyB[inj_addr] <= copyB[inj_addr] ^ inj_mask;
                    2'd2:    copyC[inj_addr] <= copyC[inj_addr] ^ inj_mask;
                    default: ;
                endcase
            end
            if (fixWrite) begin
                copyA[ptr] <= votedReg;
                copyB[ptr] <= votedReg;
                copyC[ptr] <= votedReg;
            end
            if (wr_en) begin
                copyA[wr_addr] <= wr_data;
                copyB[wr_addr] <= wr_data;
                copyC[wr_addr] <= wr_data;
            end
        end
    end

    // Registered voted read port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_data <= '0;
        else       rd_data <= rdVoted;
    end

    // Correction report; address and mask hold until the next correction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_pulse <= 1'b0;
            err_addr  <= '0;
            err_copy  <= '0;
        end else begin
            err_pulse <= fixWrite;
            if (fixWrite) begin
                err_addr <= ptr;
                err_copy <= maskReg;
            end
        end
    end

    // Saturating correction counter; clear wins over a concurrent increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                             errCnt <= '0;
        else if (err_cnt_clr)                  errCnt <= '0;
        else if (fixWrite && errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
    end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed scoreboard bench for the TMR scrub controller
module tb_tmr_scrub_ctrl;
    import tmr_scrub_pkg::*;

    localparam int SP = 4;

    logic       clk = 0, rstn = 0, wr_en = 0, scrub_en = 0, inj_en = 0, err_cnt_clr = 0;
    logic [2:0] wr_addr = '0, rd_addr = '0, inj_addr = '0;
    logic [7:0] wr_data = '0, inj_mask = '0;
    logic [1:0] inj_copy = '0;
    logic [7:0] rd_data;
    logic       err_pulse, busy;
    logic [2:0] err_addr, err_copy;
    logic [15:0] err_cnt;

    int nChecks = 0, nFails = 0, nPulses = 0;
    logic [5:0] expErrQ[$];
    logic [7:0] rdQ[$];
    logic [5:0] expErr;

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(.N_REGS(8), .WIDTH(8), .SCRUB_PERIOD(SP)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .scrub_en(scrub_en), .inj_en(inj_en),
        .inj_addr(inj_addr), .inj_copy(inj_copy), .inj_mask(inj_mask),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_copy(err_copy),
        .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readChk(input logic [2:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        rdQ.push_back(exp);
        tick();
        chk(tag, rd_data, rdQ.pop_front());
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic inject(input logic [2:0] a, input logic [1:0] cp, input logic [7:0] m);
        inj_en = 1; inj_addr = a; inj_copy = cp; inj_mask = m;
        tick();
        inj_en = 0;
    endtask

    task automatic waitQ(input string tag);
        for (int i = 0; i < 200 && expErrQ.size() != 0; i++) tick();
        chk(tag, expErrQ.size(), 0);
        tick();
    endtask

    task automatic waitAt(input scrubState_t s, input logic [2:0] a, input string tag);
        for (int i = 0; i < 200 && !(dut.state == s && dut.ptr == a); i++) tick();
        chk(tag, (dut.state == s && dut.ptr == a), 1);
    endtask

    task automatic copiesChk(input logic [2:0] a, input logic [7:0] exp, input string tag);
        chk({tag, "A"}, dut.copyA[a], exp);
        chk({tag, "B"}, dut.copyB[a], exp);
        chk({tag, "C"}, dut.copyC[a], exp);
    endtask

    // Every correction pulse must match the oldest expected {addr, copy mask}
    always @(negedge clk) begin
        if (rstn && err_pulse) begin
            nPulses++;
            if (expErrQ.size() == 0) chk("pulseExpected", expErrQ.size(), 1);
            else begin
                expErr = expErrQ.pop_front();
                chk("errAddr", err_addr, expErr[5:3]);
                chk("errCopy", err_copy, expErr[2:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] visited;
        logic       wrapped, sawBusy;
        logic [2:0] prev;
        logic [7:0] orAll;
        int         pulsesBefore;

        tick();
        chk("rstRd", rd_data, 0);
        chk("rstPulse", err_pulse, 0);
        chk("rstErrAddr", err_addr, 0);
        chk("rstErrCopy", err_copy, 0);
        chk("rstErrCnt", err_cnt, 0);
        chk("rstBusy", busy, 0);
        rstn = 1;
        tick();

        writeReg(3'd3, 8'hA5);
        readChk(3'd3, 8'hA5, "rdA5");
        chk("errCnt0", err_cnt, 0);

        inject(3'd3, 2'd1, 8'h01);
        chk("copyBFaulty", dut.copyB[3], 8'hA4);
        readChk(3'd3, 8'hA5, "rdMasked");
        expErrQ.push_back({3'd3, 3'b010});
        scrub_en = 1;
        waitQ("scrubFix3");
        scrub_en = 0;
        tick();
        chk("errCnt1", err_cnt, 1);
        copiesChk(3'd3, 8'hA5, "fixed3");

        inject(3'd3, 2'd3, 8'hFF);
        copiesChk(3'd3, 8'hA5, "injNop");
        wr_en = 1; wr_addr = 3'd5; wr_data = 8'h5A;
        inj_en = 1; inj_addr = 3'd5; inj_copy = 2'd0; inj_mask = 8'hFF;
        tick();
        wr_en = 0; inj_en = 0;
        copiesChk(3'd5, 8'h5A, "wrBeatsInj");

        pulsesBefore = nPulses;
        visited = '0; wrapped = 0; sawBusy = 0;
        prev = dut.ptr;
        scrub_en = 1;
        repeat (8 * (SP + 1) + 10) begin
            tick();
            visited[dut.ptr] = 1'b1;
            if (prev == 3'd7 && dut.ptr == 3'd0) wrapped = 1;
            if (busy) sawBusy = 1;
            prev = dut.ptr;
        end
        scrub_en = 0;
        tick(); tick();
        chk("ptrVisited", visited, 8'hFF);
        chk("ptrWrapped", wrapped, 1);
        chk("busySeen", sawBusy, 1);
        chk("noPulseClean", nPulses, pulsesBefore);
        chk("errCntHold", err_cnt, 1);
        chk("errAddrHold", err_addr, 3);
        chk("errCopyHold", err_copy, 3'b010);

        inject(3'd6, 2'd0, 8'h10);
        scrub_en = 1;
        waitAt(VOTE, 3'd6, "reachVote6");
        wr_en = 1; wr_addr = 3'd6; wr_data = 8'h3C;
        tick();
        wr_en = 0; scrub_en = 0;
        chk("ptrAfterCancel", dut.ptr, 7);
        tick(); tick();
        chk("errCntCancel", err_cnt, 1);
        copiesChk(3'd6, 8'h3C, "cancel6");
        readChk(3'd6, 8'h3C, "rdCancel");

        force dut.errCnt = 16'hFFFE;
        tick();
        release dut.errCnt;
        tick();
        chk("preload", err_cnt, 16'hFFFE);
        inject(3'd1, 2'd2, 8'h80);
        expErrQ.push_back({3'd1, 3'b100});
        scrub_en = 1;
        waitQ("fix1");
        scrub_en = 0;
        chk("errCntFull", err_cnt, 16'hFFFF);
        inject(3'd2, 2'd0, 8'hFF);
        expErrQ.push_back({3'd2, 3'b001});
        scrub_en = 1;
        waitAt(VOTE, 3'd2, "reachVote2");
        scrub_en = 0;
        waitQ("fix2Disabled");
        chk("errCntSat", err_cnt, 16'hFFFF);
        copiesChk(3'd2, 8'h00, "fixed2");
        inject(3'd4, 2'd1, 8'h0F);
        expErrQ.push_back({3'd4, 3'b010});
        scrub_en = 1;
        waitAt(FIX, 3'd4, "reachFix4");
        err_cnt_clr = 1;
        tick();
        err_cnt_clr = 0; scrub_en = 0;
        chk("clrWins", err_cnt, 0);
        waitQ("fix4");

        inject(3'd0, 2'd2, 8'h55);
        scrub_en = 1;
        waitAt(FIX, 3'd0, "reachFix0");
        rstn = 0;
        #1;
        chk("rstMidIdle", (dut.state == IDLE), 1);
        chk("rstMidPtr", dut.ptr, 0);
        chk("rstMidRd", rd_data, 0);
        chk("rstMidPulse", err_pulse, 0);
        chk("rstMidErrAddr", err_addr, 0);
        chk("rstMidErrCopy", err_copy, 0);
        chk("rstMidErrCnt", err_cnt, 0);
        chk("rstMidBusy", busy, 0);
        orAll = '0;
        for (int i = 0; i < 8; i++) orAll = orAll | dut.copyA[i] | dut.copyB[i] | dut.copyC[i];
        chk("rstMidCopies", orAll, 0);
        scrub_en = 0;
        tick();
        rstn = 1;
        tick();
        readChk(3'd3, 8'h00, "rdAfterRst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/tmr_scrub_ctrl.md
TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

Interface
REQ-001 Parameter N_REGS, default 8, number of triplicated registers (power of 2, >=2).
REQ-002 Parameter WIDTH, default 8, register word width.
REQ-003 Parameter SCRUB_PERIOD, default 16, IDLE cycles between scrub passes (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  user write strobe.
REQ-007 wr_addr  input  log2(N_REGS)  user write address.
REQ-008 wr_data  input  WIDTH  user write data.
REQ-009 rd_addr  input  log2(N_REGS)  read address.
REQ-010 rd_data  output  WIDTH  voted word at rd_addr, registered.
REQ-011 scrub_en  input  1  enables periodic scrubbing.
REQ-012 inj_en  input  1  fault-injection strobe.
REQ-013 inj_addr  input  log2(N_REGS)  injection target register.
REQ-014 inj_copy  input  2  target copy: 0=A, 1=B, 2=C, 3=no-op.
REQ-015 inj_mask  input  WIDTH  bits XORed into target copy.
REQ-016 err_pulse  output  1  one-cycle pulse on corrected mismatch.
REQ-017 err_addr  output  log2(N_REGS)  address of last corrected register.
REQ-018 err_copy  output  3  mismatching-copy mask {C,B,A} of last correction.
REQ-019 err_cnt  output  16  saturating corrected-error count.
REQ-020 err_cnt_clr  input  1  synchronous counter clear.
REQ-021 busy  output  1  high in VOTE or FIX.

Function
REQ-022 Storage: three copies A/B/C per register; vote is bitwise majority; copy mismatches if it differs from voted word in any bit.
REQ-023 wr_en writes wr_data to all three copies at wr_addr on next edge, in any FSM state.
REQ-024 inj_en XORs inj_mask into selected copy; wr_en to same address in same cycle wins, injection dropped.
REQ-025 rd_data = vote(rd_addr) sampled at edge; latency 1 cycle; reflects writes from earlier edges only.
REQ-026 FSM states IDLE, VOTE, FIX.
REQ-027 IDLE: scrub_en=1 -> timer increments; at timer==SCRUB_PERIOD-1 timer clears, go VOTE; scrub_en=0 -> timer held at 0.
REQ-028 VOTE (1 cycle): register voted word and mismatch mask of register ptr; mask nonzero -> FIX, else IDLE and ptr increments.
REQ-029 FIX (1 cycle): write voted word to all three copies at ptr; err_pulse=1, err_addr=ptr, err_copy=mask; err_cnt+1; go IDLE; ptr increments.
REQ-030 ptr wraps N_REGS-1 -> 0.
REQ-031 wr_en to ptr during VOTE or FIX cancels the pass: no fix write, no err_pulse, no count; ptr still increments; return IDLE.
REQ-032 scrub_en deassert in VOTE/FIX: pass completes normally.
REQ-033 err_cnt saturates at 16'hFFFF; err_cnt_clr same cycle as increment -> 0.
REQ-034 err_addr/err_copy hold until next correction.

Reset
REQ-035 rstn low: all copies 0, ptr 0, timer 0, state IDLE, rd_data 0, err_pulse 0, err_addr 0, err_copy 0, err_cnt 0, busy 0.
REQ-036 Reset mid-pass aborts it with no write-back.

Structure
REQ-037 Package tmr_scrub_pkg: FSM state enum, default parameter constants, majority/mismatch function.
REQ-038 Sub-module tmr_vote3: WIDTH-bit three-input majority voter with 3-bit mismatch mask; instanced for read and scrub paths.

Verification
REQ-039 Reset, write 8'hA5 to addr 3, rd_addr=3 -> rd_data=8'hA5 one cycle later, err_cnt=0.
REQ-040 Inject mask 8'h01 into copy B addr 3; rd_data stays 8'hA5; scrub reaches addr 3 -> err_pulse once, err_addr=3, err_copy=3'b010, err_cnt=1, all copies 8'hA5 afterward.
REQ-041 scrub_en=1, no faults, 8*SCRUB_PERIOD+overhead cycles -> ptr visits 0..7 and wraps to 0, no err_pulse.
REQ-042 Fault at ptr address, wr_en to same address during VOTE -> no err_pulse, err_cnt unchanged, register holds written value.
REQ-043 Preload err_cnt to 16'hFFFF via repeated faults, one more fault -> stays 16'hFFFF; err_cnt_clr with concurrent fix -> 0.
REQ-044 Assert rstn low during FIX -> all outputs and copies 0, state IDLE.
